// File: rtl/eth_fcs_inserter_if.sv
// Byte-enabled AXI-Stream link used on both sides of the FCS inserter.
// Byte i of tdata sits at [8i+:8]; byte 0 goes on the wire first.
interface eth_fcs_inserter_if #(
    parameter int SLICE_LENGTH = 8
);
    logic [8*SLICE_LENGTH-1:0] tdata;
    logic [SLICE_LENGTH-1:0]   tkeep;
    logic                      tlast;
    logic                      tvalid;
    logic                      tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_fcs_inserter.sv
// Transmit FCS stage: feeds an external combinational CRC-32 engine and appends the
// 4-byte FCS to each frame, spilling into one extra beat when the last beat is too full.

module eth_fcs_inserter_chk #(
    parameter int SLICE_LENGTH = 8
) (
    input logic                    clk,
    input logic                    reset,
    input logic                    tvalid,
    input logic [SLICE_LENGTH-1:0] tkeep,
    input logic                    tlast
);
    localparam logic [SLICE_LENGTH-1:0] KEEP_ONE = SLICE_LENGTH'(1);

    // Input keep must be non-empty, contiguous from bit 0, and full on non-last beats.
    assert property (@(posedge clk) disable iff (reset)
        tvalid |-> (tkeep != '0) && ((tkeep & (tkeep + KEEP_ONE)) == '0) && (tlast || (&tkeep)));
endmodule

module eth_fcs_inserter #(
    parameter int SLICE_LENGTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    eth_fcs_inserter_if.slave         s_axis,
    eth_fcs_inserter_if.master        m_axis,
    output logic [8*SLICE_LENGTH-1:0] crc_data,
    output logic [SLICE_LENGTH-1:0]   crc_valid,
    output logic                      crc_reset,
    input  logic [31:0]               crc_in
);
    localparam int N         = SLICE_LENGTH;
    localparam int W         = 8 * SLICE_LENGTH;
    localparam int FCS_BYTES = 4;

    typedef enum logic [0:0] {PASS = 1'b0, EXTRA = 1'b1} state_t;

    state_t         state_r, state_nxt_s;
    logic [W-1:0]   m_tdata_r, data_nxt_s, beat_data_s;
    logic [N-1:0]   m_tkeep_r, keep_nxt_s, beat_keep_s;
    logic           m_tlast_r, last_nxt_s;
    logic           m_tvalid_r, valid_nxt_s;
    logic [31:0]    fcs_r, fcs_nxt_s, spill_fcs_s;
    logic [3:0]     extra_keep_r, extra_keep_nxt_s, spill_keep_s;
    logic           load_s, ready_s, acc_s, spill_s;
    logic [1:0]     spill_cnt_s;
    int             k_s;

    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        case (idx)
            2'd0:    fcs_byte = crc[7:0];
            2'd1:    fcs_byte = crc[15:8];
            2'd2:    fcs_byte = crc[23:16];
            default: fcs_byte = crc[31:24];
        endcase
    endfunction

    assign load_s    = !m_tvalid_r || m_axis.tready;
    assign ready_s   = !reset && (state_r == PASS) && load_s;
    assign acc_s     = s_axis.tvalid && ready_s;
    assign crc_data  = s_axis.tdata;
    assign crc_valid = s_axis.tkeep & {N{acc_s}};
    assign crc_reset = reset || (acc_s && s_axis.tlast);

    // Count valid bytes and merge the FCS (taken from crc_in this very cycle) after them.
    always_comb begin
        k_s         = 0;
        beat_data_s = '0;
        beat_keep_s = '0;
        for (int i = 0; i < N; i++) begin
            if (s_axis.tkeep[i]) begin
                k_s = i + 1;
            end else begin
                k_s = k_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i < k_s) begin
                beat_data_s[8*i+:8] = s_axis.tdata[8*i+:8];
            end else if (s_axis.tlast && ((i - k_s) < FCS_BYTES)) begin
                beat_data_s[8*i+:8] = fcs_byte(crc_in, 2'(i - k_s));
            end else begin
                beat_data_s[8*i+:8] = 8'h00;
            end
            beat_keep_s[i] = (i < k_s) || (s_axis.tlast && ((i - k_s) < FCS_BYTES));
        end
    end

    assign spill_s     = s_axis.tlast && ((k_s + FCS_BYTES) > N);
    assign spill_cnt_s = 2'(N - k_s);

    // FCS bytes that did not fit, realigned to byte 0 for the extra beat.
    always_comb begin
        spill_fcs_s  = crc_in;
        spill_keep_s = 4'hF;
        case (spill_cnt_s)
            2'd1: begin
                spill_fcs_s  = {8'h00, crc_in[31:8]};
                spill_keep_s = 4'h7;
            end
            2'd2: begin
                spill_fcs_s  = {16'h0000, crc_in[31:16]};
                spill_keep_s = 4'h3;
            end
            2'd3: begin
                spill_fcs_s  = {24'h000000, crc_in[31:24]};
                spill_keep_s = 4'h1;
            end
            default: begin
                spill_fcs_s  = crc_in;
                spill_keep_s = 4'hF;
            end
        endcase
    end

    // Next state and output-register load; outputs hold unless the register can load.
    always_comb begin
        state_nxt_s      = state_r;
        valid_nxt_s      = m_tvalid_r && !m_axis.tready;
        data_nxt_s       = m_tdata_r;
        keep_nxt_s       = m_tkeep_r;
        last_nxt_s       = m_tlast_r;
        fcs_nxt_s        = fcs_r;
        extra_keep_nxt_s = extra_keep_r;
        case (state_r)
            PASS: begin
                if (acc_s) begin
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = beat_data_s;
                    keep_nxt_s  = beat_keep_s;
                    last_nxt_s  = s_axis.tlast && !spill_s;
                    if (spill_s) begin
                        state_nxt_s      = EXTRA;
                        fcs_nxt_s        = spill_fcs_s;
                        extra_keep_nxt_s = spill_keep_s;
                    end else begin
                        state_nxt_s = PASS;
                    end
                end else begin
                    state_nxt_s = PASS;
                end
            end
            EXTRA: begin
                if (load_s) begin
                    valid_nxt_s      = 1'b1;
                    data_nxt_s       = '0;
                    data_nxt_s[31:0] = fcs_r;
                    keep_nxt_s       = '0;
                    keep_nxt_s[3:0]  = extra_keep_r;
                    last_nxt_s       = 1'b1;
                    state_nxt_s      = PASS;
                    fcs_nxt_s        = 32'h0000_0000;
                    extra_keep_nxt_s = 4'h0;
                end else begin
                    state_nxt_s = EXTRA;
                end
            end
            default: begin
                state_nxt_s = PASS;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= PASS;
            m_tvalid_r   <= 1'b0;
            m_tdata_r    <= '0;
            m_tkeep_r    <= '0;
            m_tlast_r    <= 1'b0;
            fcs_r        <= 32'h0000_0000;
            extra_keep_r <= 4'h0;
        end else begin
            state_r      <= state_nxt_s;
            m_tvalid_r   <= valid_nxt_s;
            m_tdata_r    <= data_nxt_s;
            m_tkeep_r    <= keep_nxt_s;
            m_tlast_r    <= last_nxt_s;
            fcs_r        <= fcs_nxt_s;
            extra_keep_r <= extra_keep_nxt_s;
        end
    end

    assign m_axis.tdata  = m_tdata_r;
    assign m_axis.tkeep  = m_tkeep_r;
    assign m_axis.tlast  = m_tlast_r;
    assign m_axis.tvalid = m_tvalid_r;
    assign s_axis.tready = ready_s;

    eth_fcs_inserter_chk #(.SLICE_LENGTH(N)) u_chk (
        .clk    (clk),
        .reset  (reset),
        .tvalid (s_axis.tvalid),
        .tkeep  (s_axis.tkeep),
        .tlast  (s_axis.tlast)
    );
endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Bench for eth_fcs_inserter: behavioural CRC engine, scoreboard queue fed by the
// stimulus, and an independent negedge monitor that pops and compares output beats.
`timescale 1ns/1ps
module tb_eth_fcs_inserter;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [8*N-1:0] crc_data;
    logic [N-1:0]   crc_valid;
    logic           crc_reset;
    logic [31:0]    crc_in;

    eth_fcs_inserter_if #(.SLICE_LENGTH(N)) s_if();
    eth_fcs_inserter_if #(.SLICE_LENGTH(N)) m_if();

    eth_fcs_inserter #(.SLICE_LENGTH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .crc_data  (crc_data),
        .crc_valid (crc_valid),
        .crc_reset (crc_reset),
        .crc_in    (crc_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*N-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    rand_ready = 1'b0;
    bit    gap_chk = 1'b0;
    int    gap_errs = 0;
    int    win_xfers = 0;
    int    last_xfer = 0;

    // Reflected CRC-32 (poly 0xEDB88320), one byte.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Slicing engine: combinational, inverted output, synchronous reset.
    logic [31:0] eng_r;
    logic [31:0] eng_nxt;
    always_comb begin
        eng_nxt = eng_r;
        for (int i = 0; i < N; i++)
            if (crc_valid[i]) eng_nxt = crc_byte(eng_nxt, crc_data[8*i+:8]);
    end
    assign crc_in = ~eng_nxt;
    always @(posedge clk) eng_r <= crc_reset ? 32'hFFFF_FFFF : eng_nxt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fcs_of(input logic [7:0] p[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (p[i]) c = crc_byte(c, p[i]);
        return ~c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_beat(input logic [8*N-1:0] d, input logic [N-1:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        exp_q.push_back(b);
    endtask

    // Expected output = payload bytes then FCS LSB first, cut into N-byte beats.
    task automatic push_frame(input logic [7:0] p[$]);
        logic [7:0]  w[$];
        logic [31:0] f;
        beat_t       b;
        w = p;
        f = fcs_of(p);
        for (int i = 0; i < 4; i++) w.push_back(f[8*i+:8]);
        for (int base = 0; base < w.size(); base += N) begin
            b.data = '0; b.keep = '0;
            for (int j = 0; j < N; j++)
                if (base + j < w.size()) begin
                    b.data[8*j+:8] = w[base+j];
                    b.keep[j] = 1'b1;
                end
            b.last = (base + N >= w.size());
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_accept(input string name);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 500) begin
            @(negedge clk);
            got = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_accept"}, 64'(got), 64'd1);
    endtask

    task automatic drive_beat(input logic [8*N-1:0] d, input logic [N-1:0] k, input logic l);
        s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
    endtask

    task automatic send_frame(input string name, input logic [7:0] p[$]);
        int nb;
        logic [8*N-1:0] d;
        logic [N-1:0]   k;
        nb = (p.size() + N - 1) / N;
        for (int bi = 0; bi < nb; bi++) begin
            d = '0; k = '0;
            for (int j = 0; j < N; j++)
                if (bi * N + j < p.size()) begin
                    d[8*j+:8] = p[bi*N+j];
                    k[j] = 1'b1;
                end
            drive_beat(d, k, bi == nb - 1);
            wait_accept(name);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // m_tready driver: held high, or a coin toss each cycle.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every handshake pops the scoreboard; stalled outputs must hold.
    initial begin
        bit             stall;
        logic [8*N-1:0] hd;
        logic [N-1:0]   hk;
        logic           hl;
        beat_t          e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!m_if.tvalid || m_if.tdata !== hd || m_if.tkeep !== hk || m_if.tlast !== hl) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                                 m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, hd, hk, hl);
                    end
                end
                stall = m_if.tvalid && !m_if.tready;
                hd = m_if.tdata; hk = m_if.tkeep; hl = m_if.tlast;
                if (m_if.tvalid && m_if.tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_beat: unexpected beat d=%h k=%h l=%b", m_if.tdata, m_if.tkeep, m_if.tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_if.tdata !== e.data || m_if.tkeep !== e.keep || m_if.tlast !== e.last) begin
                            errors++;
                            $display("FAIL out_beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                                     m_if.tdata, m_if.tkeep, m_if.tlast, e.data, e.keep, e.last);
                        end
                    end
                    if (gap_chk) begin
                        if (win_xfers > 0 && cyc != last_xfer + 1) gap_errs++;
                        win_xfers++;
                        last_xfer = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s123[$];
        logic [7:0] p[$];
        int len;
        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", m_if.tdata, 64'd0);
        chk("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
        chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_crc_reset", 64'(crc_reset), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_s_tready", 64'(s_if.tready), 64'd1);

        // 1: "123456789", FCS CBF43926 fits in the last beat.
        push_beat(64'h3837363534333231, 8'hFF, 1'b0);
        push_beat(64'h000000CBF4392639, 8'h1F, 1'b1);
        send_frame("t1", s123);
        drain("t1");

        // 2: 8-byte frame, full 4-byte extra beat, one-cycle s_tready drop.
        p = {};
        for (int i = 0; i < 8; i++) p.push_back(8'(8'hA0 + i));
        push_frame(p);
        send_frame("t2", p);
        chk("t2_tready_low", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        chk("t2_tready_back", 64'(s_if.tready), 64'd1);
        drain("t2");

        // 3: 14-byte frame, 2 FCS bytes in the last beat, 2 spill.
        p = {};
        for (int i = 0; i < 14; i++) p.push_back(8'(8'h11 * i + 8'h05));
        push_frame(p);
        send_frame("t3", p);
        drain("t3");

        // 4: back-to-back "123456789", no output bubbles.
        gap_chk = 1'b1; win_xfers = 0; gap_errs = 0;
        for (int r = 0; r < 2; r++) begin
            push_beat(64'h3837363534333231, 8'hFF, 1'b0);
            push_beat(64'h000000CBF4392639, 8'h1F, 1'b1);
        end
        send_frame("t4a", s123);
        send_frame("t4b", s123);
        drain("t4");
        gap_chk = 1'b0;
        chk("t4_gaps", 64'(gap_errs), 64'd0);
        chk("t4_xfers", 64'(win_xfers), 64'd4);

        // 5: random lengths with random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 64);
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            push_frame(p);
            send_frame("t5", p);
        end
        drain("t5");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // 6: reset while beat 2 of 3 is offered; only beat 0 leaves the DUT.
        push_beat(64'h0706050403020100, 8'hFF, 1'b0);
        drive_beat(64'h0706050403020100, 8'hFF, 1'b0);
        wait_accept("t6b0");
        drive_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
        wait_accept("t6b1");
        drive_beat(64'h0000000013121110, 8'h0F, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t6_rst_tready", 64'(s_if.tready), 64'd0);
        chk("t6_rst_crc_reset", 64'(crc_reset), 64'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_tvalid_after", 64'(m_if.tvalid), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_beat(64'h3837363534333231, 8'hFF, 1'b0);
        push_beat(64'h000000CBF4392639, 8'h1F, 1'b1);
        send_frame("t6", s123);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
